alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle_pkg.sv | 29 ++
 rtl/alu_multicycle_mul.sv | 59 +++++
 rtl/alu_multicycle.sv | 157 +++++++++++++++
 tb/tb_alu_multicycle.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_multicycle_pkg
// Brief   : Opcode and FSM state types shared by the multicycle ALU.
// Revision: 1.0 - initial release
// ============================================================================
package alu_multicycle_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_multicycle_mul.sv
`default_nettype none
// ============================================================================
// Module  : alu_multicycle_mul
// Brief   : Iterative shift-add multiplier, one partial product per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module alu_multicycle_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;

  // prod is the accumulator including this cycle's partial product, so the
  // full product is available combinationally in the cycle done is high.
  assign prod = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done = r_busy && (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
    end else if (r_busy) begin
      r_acc    <= prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module  : alu_multicycle
// Brief   : Registered ALU with valid/ready handshakes; iterative MUL is
//           built only when ALU_MULTICYCLE_MUL_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] result,
  output logic            carry,
  output logic            zero,
  output logic            ovf
);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_zero;
  logic               r_ovf;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH:0]     w_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;

  assign w_accept = in_valid && in_ready;

`ifdef ALU_MULTICYCLE_MUL_EN
  assign w_is_mul = (op == OP_MUL);

  alu_multicycle_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept && w_is_mul),
    .a     (a),
    .b     (b),
    .done  (w_mul_done),
    .prod  (w_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_prod     = '0;
`endif

  // Single-cycle datapath; MUL without the multiplier yields all-zero.
  always_comb begin
    w_ext   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        w_ext   = {1'b0, a} + {1'b0, b};
        w_res   = w_ext[WIDTH-1:0];
        w_carry = w_ext[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_ext   = {1'b0, a} - {1'b0, b};
        w_res   = w_ext[WIDTH-1:0];
        w_carry = w_ext[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL: begin
        // The extra MSB captures the last bit shifted out (0 for shift 0).
        w_ext   = {1'b0, a} << b[SHW-1:0];
        w_res   = w_ext[WIDTH-1:0];
        w_carry = w_ext[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    if (w_accept) begin
      w_state_nxt = w_is_mul ? BUSY : DONE;
    end else begin
      case (r_state)
        BUSY:    if (w_mul_done) w_state_nxt = DONE;
        DONE:    if (out_ready)  w_state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_mul_done) begin
      r_result <= w_prod[WIDTH-1:0];
      r_carry  <= |w_prod[2*WIDTH-1:WIDTH];
      r_zero   <= ~|w_prod[WIDTH-1:0];
      r_ovf    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_carry  <= w_carry;
      r_zero   <= ~|w_res;
      r_ovf    <= w_ovf;
    end
  end

  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_multicycle
// Brief   : Scoreboard bench for alu_multicycle (WIDTH=8), directed and random.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  localparam int WIDTH = 8;
  localparam int M     = 1 << WIDTH;
  localparam int H     = M / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, carry, zero, ovf;
  logic [WIDTH-1:0] a = '0, b = '0, result;
  logic [2:0]       op = '0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c, z, v;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   head_seen = 0, rnd_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rnd_bp) begin
    #1 out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected none (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, z, v, input int lat);
    exp_t e;
    e.res = r; e.c = c; e.z = z; e.v = v; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Reference model from plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int x, input int y, input int o);
    exp_t   e;
    longint full;
    int     sx, sy, s, sh;
    e = mk('0, 1'b0, 1'b0, 1'b0, 0);
    full = 0;
    sx = (x >= H) ? x - M : x;
    sy = (y >= H) ? y - M : y;
    case (o)
      0: begin
        full = x + y; e.c = (full >= M);
        s = sx + sy;  e.v = (s >= H) || (s < -H);
      end
      1: begin
        full = x - y + M; e.c = (x < y);
        s = sx - sy;      e.v = (s >= H) || (s < -H);
      end
      2: full = x & y;
      3: full = x | y;
      4: full = x ^ y;
      5: full = M - 1 - x;
      6: begin
        sh = y % WIDTH;
        full = longint'(x) << sh;
        e.c = ((full / M) % 2) != 0;
      end
      default: begin
`ifdef ALU_MULTICYCLE_MUL_EN
        full = longint'(x) * longint'(y);
        e.c = (full >= M);
        e.lat = WIDTH;
`else
        full = 0;
`endif
      end
    endcase
    e.res = WIDTH'(full % M);
    e.z = (e.res == 0);
    return e;
  endfunction

  // Monitor: checks every presented output (including held ones) against the head.
  always @(negedge clk) if (rst_n && out_valid) begin
    if (sb.size() == 0) begin
      fail_now("unexpected_out_valid");
    end else begin
      if (!head_seen) begin
        chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        head_seen = 1;
      end
      chk("result", 64'(result), 64'(sb[0].res));
      chk("carry",  64'(carry),  64'(sb[0].c));
      chk("zero",   64'(zero),   64'(sb[0].z));
      chk("ovf",    64'(ovf),    64'(sb[0].v));
      if (out_ready) begin
        void'(sb.pop_front());
        head_seen = 0;
      end
    end
  end

  task automatic issue(input int x, input int y, input int o, input exp_t e);
    int t = 0;
    a = WIDTH'(x); b = WIDTH'(y); op = 3'(o); in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
    end else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_result"},    64'(result),    64'd0);
    chk({tag, "_carry"},     64'(carry),     64'd0);
    chk({tag, "_zero"},      64'(zero),      64'd0);
    chk({tag, "_ovf"},       64'(ovf),       64'd0);
  endtask

  initial begin
    int lo, hi, t0, x, y, o;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    issue(8'hFF, 8'h01, 0, mk(8'h00, 1, 1, 0, 0)); in_valid = 0; drain();
    issue(8'h80, 8'h01, 1, mk(8'h7F, 0, 0, 1, 0));
    issue(8'h01, 8'h02, 1, mk(8'hFF, 1, 0, 0, 0)); in_valid = 0; drain();
    issue(8'h7F, 8'h01, 0, mk(8'h80, 0, 0, 1, 0));
    issue(8'h03, 8'h07, 6, mk(8'h80, 1, 0, 0, 0));
    issue(8'h81, 8'h00, 6, mk(8'h81, 0, 0, 0, 0));
    issue(8'h5A, 8'h00, 5, mk(8'hA5, 0, 0, 0, 0)); in_valid = 0; drain();

`ifdef ALU_MULTICYCLE_MUL_EN
    issue(8'h10, 8'h10, 7, mk(8'h00, 1, 1, 0, WIDTH)); in_valid = 0;
    lo = 0;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (!in_ready) lo++;
    end
    chk("mul_in_ready_low_cycles", 64'(lo), 64'(WIDTH));
    drain();
    issue(8'h0F, 8'h0F, 7, mk(8'hE1, 0, 0, 0, WIDTH)); in_valid = 0; drain();
`else
    issue(8'h10, 8'h10, 7, mk(8'h00, 0, 1, 0, 0)); in_valid = 0; drain();
`endif

    // Back-pressure hold, then consume + accept in the same cycle.
    out_ready = 1'b0;
    issue(8'h81, 8'h01, 6, mk(8'h02, 1, 0, 0, 0)); in_valid = 0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    issue(8'hF0, 8'hFF, 4, mk(8'h0F, 0, 0, 0, 0)); in_valid = 0; drain();

    // Streaming of single-cycle ops.
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      x = $urandom_range(0, M - 1); y = $urandom_range(0, M - 1); o = $urandom_range(0, 6);
      issue(x, y, o, model(x, y, o));
    end
    chk("stream_cycles", 64'(cyc - t0), 64'd10);
    in_valid = 0; drain();

    // Random ops with random back-pressure and input gaps.
    rnd_bp = 1;
    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(0, M - 1); y = $urandom_range(0, M - 1); o = $urandom_range(0, 7);
      issue(x, y, o, model(x, y, o));
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
    end
    in_valid = 0;
    rnd_bp = 0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    // Reset in the middle of an operation.
`ifdef ALU_MULTICYCLE_MUL_EN
    issue(8'h33, 8'h05, 7, model(8'h33, 8'h05, 7)); in_valid = 0;
    repeat (3) @(posedge clk);
`else
    out_ready = 1'b0;
    issue(8'h33, 8'h05, 0, model(8'h33, 8'h05, 0)); in_valid = 0;
    repeat (2) @(posedge clk);
`endif
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    sb.delete();
    head_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    hi = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (out_valid) hi++;
    end
    chk("no_valid_after_reset", 64'(hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
